// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI receive deserializer feeding a small show-ahead FIFO.
// Samples one sdi bit per clk while ss is low and assembles DATA_W-bit words.
// Optional build macro SPI_RX_LSB_FIRST_EN: first sampled bit lands in bit 0
// (default is MSB first, matching the transmit shift stage).
module spi_rx_deser #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEAD       = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_ss,
  input  logic                         i_sdi,
  input  logic                         i_rd_ready,
  input  logic                         i_clr_err,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         o_overflow,
  output logic                         o_frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_HOLD} state_t;

  state_t              r_state, w_next;
  logic [BW-1:0]       r_bit_cnt;
  logic [3:0]          r_lead_cnt;
  logic [DATA_W-1:0]   r_sr;
  logic                r_wr_vld;
  logic [DATA_W-1:0]   r_wr_data;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_ovf, r_ferr;

  logic                w_shift, w_last, w_ferr_evt;
  logic [DATA_W-1:0]   w_word;
  logic                w_pop, w_full, w_drop, w_wr;

`ifdef SPI_RX_LSB_FIRST_EN
  assign w_word = {i_sdi, r_sr[DATA_W-1:1]};
`else
  assign w_word = {r_sr[DATA_W-2:0], i_sdi};
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic. The IDLE edge that sees ss low is the first discarded
  // lead cycle, so the LEAD state only covers the remaining LEAD-1 edges.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!i_ss) w_next = (LEAD <= 1) ? S_SHIFT : S_LEAD;
      S_LEAD:  if (i_ss) w_next = S_IDLE;
               else if (r_lead_cnt == 4'(LEAD - 1)) w_next = S_SHIFT;
      S_SHIFT: if (i_ss) w_next = S_IDLE;
               else if (w_last) w_next = S_HOLD;
      S_HOLD:  if (i_ss) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: sample enable, last-bit strobe, frame-error event.
  // With LEAD=0 the IDLE edge that sees ss low already samples bit 0.
  always_comb begin
    w_shift    = !i_ss && ((r_state == S_SHIFT) || ((r_state == S_IDLE) && (LEAD == 0)));
    w_last     = w_shift && (r_bit_cnt == BW'(DATA_W - 1));
    w_ferr_evt = (r_state == S_SHIFT) && i_ss;
  end

  // Bit/lead counters, shift register and the one-deep push stage.
  // The completed word is registered on the last-bit edge and enters the
  // FIFO on the following edge, so rd_valid rises LEAD+DATA_W+1 edges after ss.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt  <= '0;
      r_lead_cnt <= 4'd1;
      r_sr       <= '0;
      r_wr_vld   <= 1'b0;
      r_wr_data  <= '0;
    end else begin
      r_bit_cnt  <= (w_shift && !w_last) ? r_bit_cnt + 1'b1 : '0;
      r_lead_cnt <= (r_state == S_LEAD) ? r_lead_cnt + 4'd1 : 4'd1;
      if (w_shift) r_sr <= w_word;
      r_wr_vld   <= w_last;
      if (w_last) r_wr_data <= w_word;
    end
  end

  assign w_pop  = o_rd_valid && i_rd_ready;
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_drop = r_wr_vld && w_full && !w_pop;
  assign w_wr   = r_wr_vld && !w_drop;

  // FIFO storage and pointers; a pop and a push on the same edge both take
  // effect (when full, the freed head slot is exactly the write slot).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; an event on the same edge as clr_err wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_err) r_ovf <= 1'b0;
      if (w_ferr_evt)     r_ferr <= 1'b1;
      else if (i_clr_err) r_ferr <= 1'b0;
    end
  end

  assign o_rd_valid   = (r_count != '0);
  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_fifo_count = r_count;
  assign o_overflow   = r_ovf;
  assign o_frame_err  = r_ferr;
endmodule

// File: tb/tb_spi_rx_deser.sv
// Bench for spi_rx_deser: directed vector tables plus randomized frames,
// checked every edge against a queue-based reference of the receiver.
module tb_spi_rx_deser;
  localparam int DW = 8, DEPTH = 4, LEAD = 2;

  logic       clk = 1'b0, rst_n = 1'b0, ss = 1'b1, sdi = 1'b0, rd_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, frame_err;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  spi_rx_deser #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LEAD(LEAD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ss(ss), .i_sdi(sdi), .i_rd_ready(rd_ready),
    .i_clr_err(clr_err), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_fifo_count(fifo_count), .o_overflow(overflow), .o_frame_err(frame_err));

  int checks = 0, errors = 0;

  // Reference: words held by the FIFO, sticky flags, and the word that
  // completed on the previous edge (it becomes visible one edge later).
  logic [7:0] mq[$];
  bit         m_ovf = 0, m_ferr = 0, pend = 0;
  logic [7:0] pend_w = '0;

  typedef struct {
    logic [7:0] s;      // stream, s[7] sent first
    int         nbits;  // bits sent before ss rises (8 = full word)
    int         mode;   // rd_ready: 0 never, 1 always, 2 last bit only, 3 random
    logic [2:0] e_cnt;
    logic       e_ovf;
    logic       e_ferr;
  } vec_t;
  vec_t vecs[7];

  // Word the receiver should assemble from a stream sent s[7] first.
  function automatic logic [7:0] exp_word(input logic [7:0] s);
    logic [7:0] r;
`ifdef SPI_RX_LSB_FIRST_EN
    for (int k = 0; k < 8; k++) r[k] = s[7-k];
`else
    r = s;
`endif
    return r;
  endfunction

  function automatic logic rdy_of(input int mode, input bit last);
    case (mode)
      1:       return 1'b1;
      2:       return last;
      3:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("valid", 32'(rd_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("head", 32'(rd_data), 32'(mq[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  // One clock edge: drive inputs, advance the reference, compare.
  task automatic tick(input logic s, input logic d, input logic rdy, input logic clr,
                      input bit lastb, input bit ab, input logic [7:0] w);
    bit drop;
    ss = s; sdi = d; rd_ready = rdy; clr_err = clr;
    @(posedge clk);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    drop = pend && (mq.size() == DEPTH);
    if (pend && !drop) mq.push_back(pend_w);
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    if (ab) m_ferr = 1; else if (clr) m_ferr = 0;
    pend = lastb; pend_w = exp_word(w);
    #1 check_model();
  endtask

  task automatic send_frame(input logic [7:0] s, input int nbits, input int mode);
    for (int i = 0; i < LEAD; i++)
      tick(1'b0, 1'($urandom_range(0, 1)), rdy_of(mode, 0), 1'b0, 0, 0, s);
    for (int k = 0; k < nbits; k++)
      tick(1'b0, s[7-k], rdy_of(mode, k == 7), 1'b0, k == 7, 0, s);
    tick(1'b1, 1'b0, rdy_of(mode, 0), 1'b0, 0, nbits < 8, s);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    tick(1'b1, 1'b0, rdy, clr, 0, 0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (mq.size() > 0 || pend); i++) idle(1'b1, 1'b0);
    chk("drain_count", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h01, 8, 0, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 8, 0, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 8, 0, 3'd3, 1'b0, 1'b0};
    vecs[3] = '{8'h04, 8, 0, 3'd4, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 8, 0, 3'd4, 1'b1, 1'b0};
    vecs[5] = '{8'hA7, 5, 0, 3'd0, 1'b0, 1'b1};
    vecs[6] = '{8'h5D, 8, 0, 3'd1, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // ss low from the first edge after release: word visible after edge 11
    send_frame(8'b1101_0011, 8, 0);
`ifdef SPI_RX_LSB_FIRST_EN
    chk("t1_data", 32'(rd_data), 32'hCB);
`else
    chk("t1_data", 32'(rd_data), 32'hD3);
`endif
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    drain();

    // Overflow with no reads, then ordered drain
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].s, vecs[i].nbits, vecs[i].mode);
      chk("v_cnt", 32'(fifo_count), 32'(vecs[i].e_cnt));
      chk("v_ovf", 32'(overflow), 32'(vecs[i].e_ovf));
      chk("v_ferr", 32'(frame_err), 32'(vecs[i].e_ferr));
    end
    for (int i = 0; i < 4; i++) begin
      chk("order", 32'(rd_data), 32'(exp_word(8'(i + 1))));
      idle(1'b1, 1'b0);
    end
    chk("drained", 32'(fifo_count), 32'd0);
    idle(1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Aborted frame, then a good one, then clear
    for (int i = 5; i < 7; i++) begin
      send_frame(vecs[i].s, vecs[i].nbits, vecs[i].mode);
      chk("v_cnt", 32'(fifo_count), 32'(vecs[i].e_cnt));
      chk("v_ovf", 32'(overflow), 32'(vecs[i].e_ovf));
      chk("v_ferr", 32'(frame_err), 32'(vecs[i].e_ferr));
    end
    chk("t3_data", 32'(rd_data), 32'(exp_word(8'h5D)));
    idle(1'b0, 1'b1);
    chk("ferr_clr", 32'(frame_err), 32'd0);
    drain();

    // Full FIFO, word completes with a read on the last-bit edge
    for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 8, 0);
    send_frame(8'h15, 8, 2);
    chk("t4_count", 32'(fifo_count), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_head", 32'(rd_data), 32'(exp_word(8'h12)));
    drain();

    // Reset in the middle of SHIFT
    for (int i = 0; i < LEAD; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
    ss = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_data", 32'(rd_data), 32'd0);
    chk("mr_valid", 32'(rd_valid), 32'd0);
    chk("mr_count", 32'(fifo_count), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    mq.delete(); pend = 0; m_ovf = 0; m_ferr = 0;
    send_frame(8'hA5, 8, 0);
    chk("t5_data", 32'(rd_data), 32'(exp_word(8'hA5)));
    drain();

    // Pointer wrap: nine push/pop pairs
    for (int i = 0; i < 9; i++) send_frame(8'(8'h30 + 7 * i), 8, 1);
    drain();

    // Randomized frames, aborts, read pressure and clears
    for (int n = 0; n < 40; n++) begin
      logic [7:0] s;
      int nb;
      s  = 8'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      send_frame(s, nb, 3);
      for (int g = 0; g < $urandom_range(0, 2); g++)
        idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
